// File: rtl/prog_clock_divider.sv
// Runtime-programmable clock-enable divider with double-buffered period/high-time
// configuration; q, rise and fall are clk-domain enables, not generated clocks.
module prog_clock_divider #(
    parameter int WIDTH        = 16,
    parameter int DEFAULT_DIV  = 2,
    parameter int DEFAULT_HIGH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [WIDTH-1:0] cfg_div,
    input  logic [WIDTH-1:0] cfg_high,
    output logic             cfg_err,
    output logic             q,
    output logic             rise,
    output logic             fall
);

    localparam logic [WIDTH-1:0] ZERO  = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE   = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] TWO   = {{(WIDTH-2){1'b0}}, 2'b10};
    localparam logic [WIDTH-1:0] DEF_D = DEFAULT_DIV[WIDTH-1:0];
    localparam logic [WIDTH-1:0] DEF_H = DEFAULT_HIGH[WIDTH-1:0];

    function automatic logic cfg_legal(input logic [WIDTH-1:0] d, input logic [WIDTH-1:0] h);
        return (d >= TWO) && (h >= ONE) && (h < d);
    endfunction

    logic [WIDTH-1:0] div_a_r, high_a_r, div_s_r, high_s_r, cnt_r;
    logic             pending_r, running_r, q_r, rise_r, fall_r, cfg_err_r;

    logic [WIDTH-1:0] div_a_s, high_a_s, div_s_s, high_s_s, cnt_s;
    logic             pending_s, running_s, q_s, accept_s, legal_s, wrap_s, boundary_s;

    assign cfg_ready = ~pending_r;
    assign cfg_err   = cfg_err_r;
    assign q         = q_r;
    assign rise      = rise_r;
    assign fall      = fall_r;

    // Next-state: shadow apply at boundaries, config accept, and period counter.
    always_comb begin
        div_a_s    = div_a_r;
        high_a_s   = high_a_r;
        div_s_s    = div_s_r;
        high_s_s   = high_s_r;
        pending_s  = pending_r;
        cnt_s      = cnt_r;
        running_s  = running_r;
        q_s        = q_r;
        accept_s   = cfg_valid & ~pending_r;
        legal_s    = cfg_legal(cfg_div, cfg_high);
        wrap_s     = (cnt_r == (div_a_r - ONE));
        boundary_s = ~en | ~running_r | wrap_s;

        // Accept is blocked while pending, so apply and accept never overlap.
        if (pending_r && boundary_s) begin
            div_a_s   = div_s_r;
            high_a_s  = high_s_r;
            pending_s = 1'b0;
        end else if (accept_s && legal_s) begin
            div_s_s   = cfg_div;
            high_s_s  = cfg_high;
            pending_s = 1'b1;
        end else begin
            pending_s = pending_r;
        end

        if (!en) begin
            cnt_s     = ZERO;
            running_s = 1'b0;
            q_s       = 1'b0;
        end else if (!running_r || wrap_s) begin
            cnt_s     = ZERO;
            running_s = 1'b1;
            q_s       = 1'b1;
        end else begin
            cnt_s     = cnt_r + ONE;
            running_s = 1'b1;
            q_s       = ((cnt_r + ONE) < high_a_r);
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_a_r   <= DEF_D;
            high_a_r  <= DEF_H;
            div_s_r   <= DEF_D;
            high_s_r  <= DEF_H;
            pending_r <= 1'b0;
            cnt_r     <= ZERO;
            running_r <= 1'b0;
            q_r       <= 1'b0;
            rise_r    <= 1'b0;
            fall_r    <= 1'b0;
            cfg_err_r <= 1'b0;
        end else begin
            div_a_r   <= div_a_s;
            high_a_r  <= high_a_s;
            div_s_r   <= div_s_s;
            high_s_r  <= high_s_s;
            pending_r <= pending_s;
            cnt_r     <= cnt_s;
            running_r <= running_s;
            q_r       <= q_s;
            rise_r    <= q_s & ~q_r;
            fall_r    <= ~q_s & q_r;
            cfg_err_r <= accept_s & ~legal_s;
        end
    end

endmodule
